// File: rtl/baud_pkg.sv
// Shared constants and helpers for the UART baud timing generator.
// Divisor pairs are 12 MHz / baud / 16, split into integer and 1/16ths.
package baud_pkg;

    localparam int unsigned CLK_HZ      = 12_000_000;
    localparam int unsigned CLAMP_MIN   = 2;

    localparam int unsigned DIV_115200  = 6;
    localparam int unsigned FRAC_115200 = 8;
    localparam int unsigned DIV_9600    = 78;
    localparam int unsigned FRAC_9600   = 2;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/baud_prescaler.sv
// Fractional-N prescaler: counts out the current period P and flags its last cycle.
// The period length is reloaded at every boundary from div plus the accumulator carry.
module baud_prescaler
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned FRAC_W      = 4,
    parameter int unsigned DEFAULT_DIV = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              sync_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              boundary_c_o
);

    // One extra bit so div + carry never wraps.
    localparam int unsigned PER_W   = DIV_W + 1;
    localparam int unsigned RST_PER = (DEFAULT_DIV < CLAMP_MIN) ? CLAMP_MIN : DEFAULT_DIV;

    logic [PER_W-1:0]  cnt_q;
    logic [PER_W-1:0]  cnt_d;
    logic [PER_W-1:0]  per_q;
    logic [PER_W-1:0]  per_d;
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_d;
    logic [FRAC_W:0]   acc_sum;
    logic [PER_W-1:0]  div_clamped;
    logic              at_end;

    always_comb begin
        div_clamped  = (div_i < DIV_W'(CLAMP_MIN)) ? PER_W'(CLAMP_MIN) : PER_W'(div_i);
        acc_sum      = {1'b0, acc_q} + {1'b0, frac_i};
        at_end       = (cnt_q == per_q - PER_W'(1));
        boundary_c_o = en_i && !sync_i && at_end;
    end

    // Resync restarts a fresh period with no fractional history.
    always_comb begin
        cnt_d = cnt_q;
        per_d = per_q;
        acc_d = acc_q;
        if (sync_i) begin
            cnt_d = '0;
            acc_d = '0;
            per_d = div_clamped;
        end else if (boundary_c_o) begin
            cnt_d = '0;
            acc_d = acc_sum[FRAC_W-1:0];
            per_d = div_clamped + PER_W'(acc_sum[FRAC_W]);
        end else if (en_i) begin
            cnt_d = cnt_q + PER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            per_q <= PER_W'(RST_PER);
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional-N baud timing generator: oversample strobe, bit strobe and phase index.
// Runtime divisor loads are staged in a shadow register and applied at a period boundary.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned OVS          = 16,
    parameter int unsigned DEFAULT_DIV  = DIV_115200,
    parameter int unsigned DEFAULT_FRAC = FRAC_115200
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  ENABLE,
    input  logic                  LOAD,
    input  logic [DIV_W-1:0]      DIV,
    input  logic [FRAC_W-1:0]     FRAC,
    input  logic                  SYNC,
    output logic                  TICK_OS,
    output logic                  TICK_BIT,
    output logic [clog2(OVS)-1:0] PHASE
);

    localparam int unsigned     PH_W    = clog2(OVS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2);

    logic [DIV_W-1:0]  div_act_q;
    logic [DIV_W-1:0]  div_act_d;
    logic [DIV_W-1:0]  div_shd_q;
    logic [DIV_W-1:0]  div_shd_d;
    logic [DIV_W-1:0]  div_eff;
    logic [FRAC_W-1:0] frac_act_q;
    logic [FRAC_W-1:0] frac_act_d;
    logic [FRAC_W-1:0] frac_shd_q;
    logic [FRAC_W-1:0] frac_shd_d;
    logic [FRAC_W-1:0] frac_eff;
    logic              pend_q;
    logic              pend_d;
    logic [PH_W-1:0]   osc_q;
    logic [PH_W-1:0]   osc_d;
    logic              tick_os_q;
    logic              tick_os_d;
    logic              tick_bit_q;
    logic              tick_bit_d;
    logic              boundary_c;

    // Divisor the prescaler reloads from if this edge restarts a period.
    always_comb begin
        if (SYNC && LOAD) begin
            div_eff  = DIV;
            frac_eff = FRAC;
        end else if (pend_q) begin
            div_eff  = div_shd_q;
            frac_eff = frac_shd_q;
        end else begin
            div_eff  = div_act_q;
            frac_eff = frac_act_q;
        end
    end

    baud_prescaler #(
        .DIV_W       (DIV_W),
        .FRAC_W      (FRAC_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk          (CLK),
        .rst_n        (RESETN),
        .en_i         (ENABLE),
        .sync_i       (SYNC),
        .div_i        (div_eff),
        .frac_i       (frac_eff),
        .boundary_c_o (boundary_c)
    );

    always_comb begin
        div_act_d  = div_act_q;
        frac_act_d = frac_act_q;
        div_shd_d  = div_shd_q;
        frac_shd_d = frac_shd_q;
        pend_d     = pend_q;
        osc_d      = osc_q;
        tick_os_d  = 1'b0;
        tick_bit_d = 1'b0;
        if (SYNC) begin
            osc_d      = PH_MID;
            div_act_d  = div_eff;
            frac_act_d = frac_eff;
            pend_d     = 1'b0;
            if (LOAD) begin
                div_shd_d  = DIV;
                frac_shd_d = FRAC;
            end
        end else begin
            if (boundary_c) begin
                div_act_d  = div_eff;
                frac_act_d = frac_eff;
                pend_d     = 1'b0;
                osc_d      = osc_q + PH_W'(1);
                tick_os_d  = 1'b1;
                tick_bit_d = (osc_q == PH_LAST);
            end
            // A load on a boundary edge waits for the following boundary.
            if (LOAD) begin
                div_shd_d  = DIV;
                frac_shd_d = FRAC;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            div_act_q  <= DIV_W'(DEFAULT_DIV);
            frac_act_q <= FRAC_W'(DEFAULT_FRAC);
            div_shd_q  <= DIV_W'(DEFAULT_DIV);
            frac_shd_q <= FRAC_W'(DEFAULT_FRAC);
            pend_q     <= 1'b0;
            osc_q      <= '0;
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
        end else begin
            div_act_q  <= div_act_d;
            frac_act_q <= frac_act_d;
            div_shd_q  <= div_shd_d;
            frac_shd_q <= frac_shd_d;
            pend_q     <= pend_d;
            osc_q      <= osc_d;
            tick_os_q  <= tick_os_d;
            tick_bit_q <= tick_bit_d;
        end
    end

    assign TICK_OS  = tick_os_q;
    assign TICK_BIT = tick_bit_q;
    assign PHASE    = osc_q;

endmodule
